ptp_slave_seq: RTL and testbench
================================

# ptp_slave_seq

Slave-side sequencer for the four-timestamp precise-time exchange. It sits between the packet parser/builder and the cycle-timer/offset-correction block. It does the following:
- turns received Sync and Delay_Resp events into the `ts_1`/`ts_2_record`/`ts_3`/`ts_4` strobes;
- requests the Delay_Req transmission;
- fires a single `status_ok` pulse once all four timestamps are held, which starts the offset calculation.

Timeouts and overlapping exchanges are handled here, so the correction block only ever sees complete, consistent sets.

## Interface
Parameters:
- `REQ_GAP`, 16: cycles between the Sync capture and the `send_req` assertion (range 1..65535).
- `TIMEOUT_CYC`, 500000: maximum cycles spent in WAIT_TX plus WAIT_RESP (4 ms at 125 MHz).
- `CYC_MAX`, 124999: last value of the sub-millisecond field.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: 125 MHz system clock.
- `reset` in 1: asynchronous, active-high reset.
- `m_or_s` in 1: 1 = master (sequencer idle), 0 = slave.
- `timer` in 48: local time `{ms[30:0], cyc[16:0]}`.
- `sync_rx` in 1: one-cycle pulse when a Sync packet is parsed.
- `sync_ts` in 48: master origin timestamp, valid with `sync_rx`.
- `req_ready` in 1: packet builder accepts a Delay_Req.
- `req_tx_done` in 1: one-cycle pulse when the Delay_Req leaves the MAC.
- `resp_rx` in 1: one-cycle pulse when a Delay_Resp is parsed.
- `resp_ts` in 48: master receive timestamp, valid with `resp_rx`.
- `ts_1_valid`, `ts_2_record`, `ts_3_valid`, `ts_4_valid` out 1: one-cycle capture strobes.
- `ts_1`, `ts_3`, `ts_4` out 48: registered timestamps.
- `send_req` out 1: Delay_Req request (valid, paired with `req_ready`).
- `status_ok` out 1: one-cycle pulse, exchange complete.
- `timeout_err` out 1: one-cycle pulse, exchange abandoned.
- `done_cnt`, `to_cnt` out 16: saturating counts of completed and timed-out exchanges.

## Operation
- States:
  - IDLE
  - GAP
  - REQ
  - WAIT_TX
  - WAIT_RESP
  - DONE
- IDLE:
  - When `sync_rx` and `m_or_s=0`: set `ts_1<=sync_ts`, pulse `ts_1_valid` and `ts_2_record` in the following cycle, load the gap counter with `REQ_GAP-1`, go to GAP.
- GAP:
  - Count down; at 0, go to REQ.
- REQ:
  - Hold `send_req=1`. The transfer happens on the cycle where `send_req && req_ready`.
  - Then go to WAIT_TX and clear the timeout counter.
- WAIT_TX:
  - On `req_tx_done`: set `ts_3<=timer`, pulse `ts_3_valid`, go to WAIT_RESP.
- WAIT_RESP:
  - On `resp_rx`: set `ts_4<=resp_ts`, pulse `ts_4_valid`, go to DONE.
- DONE:
  - Pulse `status_ok` for one cycle, increment `done_cnt`, return to IDLE.
- Timeout:
  - The counter runs in WAIT_TX and WAIT_RESP.
  - On reaching `TIMEOUT_CYC-1`: pulse `timeout_err`, increment `to_cnt`, go to IDLE. No `status_ok` is issued.
- Overlap:
  - `sync_rx` in any state other than IDLE or DONE restarts the exchange exactly as the IDLE entry does.
  - This does not count as a timeout.
- Ignored events:
  - `resp_rx` outside WAIT_RESP is ignored.
  - `req_tx_done` outside WAIT_TX is ignored.
- `m_or_s` behaviour:
  - `m_or_s=1` forces IDLE and blocks all strobes.
  - A change of `m_or_s` mid-exchange aborts silently: no `timeout_err`.
- Counters saturate at 16'hFFFF.
- Timestamps are passed through unmodified; no arithmetic on the `ms`/`cyc` fields.

## Timing
- Reset values:
  - All outputs 0.
  - `ts_1`, `ts_3`, `ts_4` = 48'h0.
  - State = IDLE.
  - Reset mid-exchange discards everything; no pulses are emitted.
- Sync capture:
  - With `sync_rx` at cycle N, `ts_1`, `ts_1_valid` and `ts_2_record` are high at N+1.
  - The downstream block therefore samples `timer` at N+1 as t2.
- Request:
  - `send_req` rises at N+1+`REQ_GAP`.
  - It stays high until the handshake cycle and falls on the next cycle.
- Transmit timestamp:
  - With `req_tx_done` at cycle M, `ts_3` equals `timer` sampled at M.
  - `ts_3_valid` is high at M+1.
- Completion:
  - With `resp_rx` at cycle K, `ts_4_valid` is high at K+1 and `status_ok` at K+2.
  - This guarantees the downstream registers hold all four values before `status_ok`.
- Simultaneous events:
  - `sync_rx` together with `resp_rx` in WAIT_RESP: restart wins and `resp_rx` is dropped.
  - Timeout in the same cycle as the awaited event: the event wins.

## Structure
- Shared package holds:
  - state enum;
  - `TS_W=48`, `MS_W=31`, `CYC_W=17`, `CYC_MAX`;
  - the timestamp typedef `{ms, cyc}`.
- Single module, no sub-modules. The timeout/gap logic is one shared down/up counter selected by state.

## Test plan
- Nominal exchange:
  - Stimulus: `sync_rx` with `sync_ts`=0x0000_0002_0010; `req_ready` tied 1; `req_tx_done` 40 cycles after `send_req`; `resp_rx` with 0x0000_0002_1000.
  - Required: strobes at the stated cycles, `ts_3` equal to `timer` at the `req_tx_done` cycle, one `status_ok`, `done_cnt`=1.
- Back-pressure:
  - Stimulus: `req_ready` low for 20 cycles.
  - Required: `send_req` held for all 20 cycles, exactly one handshake.
- Timeout:
  - Stimulus: no `resp_rx`; `TIMEOUT_CYC`=1000.
  - Required: `timeout_err` exactly 1000 cycles after WAIT_TX entry, `to_cnt`=1, no `status_ok`.
- Overlap:
  - Stimulus: second `sync_rx` during WAIT_RESP.
  - Required: new `ts_1`/`ts_2_record` strobes, the old `resp_rx` ignored, completion only on the next `resp_rx`.
- Master mode and reset:
  - Stimulus: `m_or_s=1` with `sync_rx`.
  - Required: no strobes.
  - Stimulus: `reset` asserted mid-WAIT_TX.
  - Required: all outputs 0, state IDLE.
- Counter saturation:
  - Stimulus: preload `done_cnt` to 0xFFFF, then complete an exchange.
  - Required: `done_cnt` stays at 0xFFFF.

Source files
------------

// File: rtl/ptp_slave_seq_pkg.sv
// rtl/ptp_slave_seq_pkg.sv - shared types and constants for the PTP slave sequencer
package ptp_slave_seq_pkg;

  localparam int TS_W  = 48;
  localparam int MS_W  = 31;
  localparam int CYC_W = 17;
  localparam int CYC_MAX = 124999;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_REQ,
    ST_WAIT_TX,
    ST_WAIT_RESP,
    ST_DONE
  } state_t;

  // Local and remote timestamps share one layout: milliseconds above sub-ms cycles.
  typedef struct packed {
    logic [MS_W-1:0]  ms;
    logic [CYC_W-1:0] cyc;
  } ts_t;

  // Event counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ptp_slave_seq.sv
// rtl/ptp_slave_seq.sv - slave-side four-timestamp exchange sequencer
import ptp_slave_seq_pkg::*;

module ptp_slave_seq #(
  parameter int REQ_GAP     = 16,
  parameter int TIMEOUT_CYC = 500000,
  parameter int CYC_MAX     = ptp_slave_seq_pkg::CYC_MAX
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m_or_s,
  input  logic [TS_W-1:0] timer,
  input  logic            sync_rx,
  input  logic [TS_W-1:0] sync_ts,
  input  logic            req_ready,
  input  logic            req_tx_done,
  input  logic            resp_rx,
  input  logic [TS_W-1:0] resp_ts,
  output logic            ts_1_valid,
  output logic            ts_2_record,
  output logic            ts_3_valid,
  output logic            ts_4_valid,
  output logic [TS_W-1:0] ts_1,
  output logic [TS_W-1:0] ts_3,
  output logic [TS_W-1:0] ts_4,
  output logic            send_req,
  output logic            status_ok,
  output logic            timeout_err,
  output logic [15:0]     done_cnt,
  output logic [15:0]     to_cnt
);

  // One counter serves both the request gap (down) and the exchange timeout (up);
  // it must reach TIMEOUT_CYC because an event on the last cycle still advances it.
  localparam int CNT_MAX = (TIMEOUT_CYC > REQ_GAP) ? TIMEOUT_CYC : REQ_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(REQ_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  ts_t              r_ts_1;
  ts_t              r_ts_3;
  ts_t              r_ts_4;
  logic             r_ts_1_valid;
  logic             r_ts_2_record;
  logic             r_ts_3_valid;
  logic             r_ts_4_valid;
  logic             r_send_req;
  logic             r_status_ok;
  logic             r_timeout_err;
  logic [15:0]      r_done_cnt;
  logic [15:0]      r_to_cnt;

  ts_t              w_timer;
  logic             w_expired;
  logic             w_restart;

  assign w_timer   = ts_t'(timer);
  assign w_expired = (r_cnt >= TO_LAST);
  // A new Sync preempts every active state; the one-cycle DONE state is allowed to finish.
  assign w_restart = sync_rx && (r_state != ST_DONE);

  // Exchange state machine with registered strobes, timestamps and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_ts_1        <= '0;
      r_ts_3        <= '0;
      r_ts_4        <= '0;
      r_ts_1_valid  <= 1'b0;
      r_ts_2_record <= 1'b0;
      r_ts_3_valid  <= 1'b0;
      r_ts_4_valid  <= 1'b0;
      r_send_req    <= 1'b0;
      r_status_ok   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_done_cnt    <= 16'h0;
      r_to_cnt      <= 16'h0;
    end else begin
      r_ts_1_valid  <= 1'b0;
      r_ts_2_record <= 1'b0;
      r_ts_3_valid  <= 1'b0;
      r_ts_4_valid  <= 1'b0;
      r_status_ok   <= 1'b0;
      r_timeout_err <= 1'b0;
      if (m_or_s) begin
        r_state    <= ST_IDLE;
        r_send_req <= 1'b0;
      end else if (w_restart) begin
        r_ts_1        <= ts_t'(sync_ts);
        r_ts_1_valid  <= 1'b1;
        r_ts_2_record <= 1'b1;
        r_cnt         <= GAP_LOAD;
        r_send_req    <= 1'b0;
        r_state       <= ST_GAP;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_send_req <= 1'b0;
          end
          ST_GAP: begin
            if (r_cnt == '0) begin
              r_send_req <= 1'b1;
              r_state    <= ST_REQ;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          ST_REQ: begin
            if (req_ready) begin
              r_send_req <= 1'b0;
              r_cnt      <= '0;
              r_state    <= ST_WAIT_TX;
            end
          end
          ST_WAIT_TX: begin
            if (req_tx_done) begin
              r_ts_3       <= w_timer;
              r_ts_3_valid <= 1'b1;
              r_cnt        <= r_cnt + CNT_W'(1);
              r_state      <= ST_WAIT_RESP;
            end else if (w_expired) begin
              r_timeout_err <= 1'b1;
              r_to_cnt      <= sat_inc(r_to_cnt);
              r_state       <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_WAIT_RESP: begin
            if (resp_rx) begin
              r_ts_4       <= ts_t'(resp_ts);
              r_ts_4_valid <= 1'b1;
              r_state      <= ST_DONE;
            end else if (w_expired) begin
              r_timeout_err <= 1'b1;
              r_to_cnt      <= sat_inc(r_to_cnt);
              r_state       <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_DONE: begin
            r_status_ok <= 1'b1;
            r_done_cnt  <= sat_inc(r_done_cnt);
            r_state     <= ST_IDLE;
          end
          default: begin
            r_send_req <= 1'b0;
            r_state    <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // The sub-millisecond field of the local timer never exceeds its last value.
  a_timer_cyc: assert property (@(posedge clk) disable iff (reset)
    w_timer.cyc <= CYC_W'(CYC_MAX));

  assign ts_1_valid  = r_ts_1_valid;
  assign ts_2_record = r_ts_2_record;
  assign ts_3_valid  = r_ts_3_valid;
  assign ts_4_valid  = r_ts_4_valid;
  assign ts_1        = r_ts_1;
  assign ts_3        = r_ts_3;
  assign ts_4        = r_ts_4;
  assign send_req    = r_send_req;
  assign status_ok   = r_status_ok;
  assign timeout_err = r_timeout_err;
  assign done_cnt    = r_done_cnt;
  assign to_cnt      = r_to_cnt;

endmodule

// File: tb/tb_ptp_slave_seq.sv
// tb/tb_ptp_slave_seq.sv - self-checking bench for ptp_slave_seq
module tb_ptp_slave_seq;

  localparam int G = 4;
  localparam int T = 1000;
  localparam int CMAX = 124999;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_or_s;
  logic [47:0] timer = {31'd7, 17'd124980};
  logic        sync_rx;
  logic [47:0] sync_ts;
  logic        req_ready;
  logic        req_tx_done;
  logic        resp_rx;
  logic [47:0] resp_ts;
  logic        ts_1_valid, ts_2_record, ts_3_valid, ts_4_valid;
  logic [47:0] ts_1, ts_3, ts_4;
  logic        send_req, status_ok, timeout_err;
  logic [15:0] done_cnt, to_cnt;

  int total = 0;
  int bad = 0;
  bit preload = 1'b0;

  ptp_slave_seq #(.REQ_GAP(G), .TIMEOUT_CYC(T), .CYC_MAX(CMAX)) dut (
    .clk(clk), .reset(reset), .m_or_s(m_or_s), .timer(timer),
    .sync_rx(sync_rx), .sync_ts(sync_ts), .req_ready(req_ready),
    .req_tx_done(req_tx_done), .resp_rx(resp_rx), .resp_ts(resp_ts),
    .ts_1_valid(ts_1_valid), .ts_2_record(ts_2_record),
    .ts_3_valid(ts_3_valid), .ts_4_valid(ts_4_valid),
    .ts_1(ts_1), .ts_3(ts_3), .ts_4(ts_4),
    .send_req(send_req), .status_ok(status_ok), .timeout_err(timeout_err),
    .done_cnt(done_cnt), .to_cnt(to_cnt)
  );

  always #5 clk = ~clk;

  // Free-running local time {ms, cyc}, cyc wrapping after CMAX.
  always @(posedge clk)
    if (timer[16:0] == 17'(CMAX)) timer <= {timer[47:17] + 31'd1, 17'd0};
    else timer <= timer + 48'd1;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (time-stamped exchange record) ----------------
  int cyc = 0;
  bit m_act = 0, m_done_pend = 0;
  int sync_t = 0, hs_t = -1, tx_t = -1;
  logic [47:0] e_ts1 = 0, e_ts3 = 0, e_ts4 = 0;
  bit e_v1, e_v2, e_v3, e_v4, e_send, e_ok, e_to;
  logic [15:0] e_done = 0, e_tocnt = 0;

  task automatic m_timeout();
    e_to = 1;
    if (e_tocnt != 16'hFFFF) e_tocnt++;
    m_act = 0;
  endtask

  always @(posedge clk) begin
    cyc++;
    e_v1 = 0; e_v2 = 0; e_v3 = 0; e_v4 = 0; e_ok = 0; e_to = 0;
    if (reset) begin
      m_act = 0; m_done_pend = 0; e_send = 0;
      e_ts1 = 0; e_ts3 = 0; e_ts4 = 0; e_done = 0; e_tocnt = 0;
    end else if (preload) begin
      e_done = 16'hFFFF;
    end else if (m_or_s) begin
      m_act = 0; m_done_pend = 0; e_send = 0;
    end else begin
      if (m_done_pend) begin
        e_ok = 1;
        if (e_done != 16'hFFFF) e_done++;
        m_done_pend = 0;
      end else if (sync_rx) begin
        e_ts1 = sync_ts; e_v1 = 1; e_v2 = 1;
        m_act = 1; sync_t = cyc; hs_t = -1; tx_t = -1;
      end else if (m_act) begin
        if (hs_t < 0) begin
          if (cyc >= sync_t + 1 + G && req_ready) hs_t = cyc;
        end else if (tx_t < 0) begin
          if (req_tx_done) begin
            tx_t = cyc; e_ts3 = timer; e_v3 = 1;
          end else if (cyc - (hs_t + 1) >= T - 1) m_timeout();
        end else begin
          if (resp_rx) begin
            e_ts4 = resp_ts; e_v4 = 1; m_act = 0; m_done_pend = 1;
          end else if (cyc - (hs_t + 1) >= T - 1) m_timeout();
        end
      end
      e_send = m_act && (hs_t < 0) && (cyc + 1 >= sync_t + 1 + G);
    end
    #1;
    chk("cyc_ts_1_valid", 48'(ts_1_valid), 48'(e_v1));
    chk("cyc_ts_2_record", 48'(ts_2_record), 48'(e_v2));
    chk("cyc_ts_3_valid", 48'(ts_3_valid), 48'(e_v3));
    chk("cyc_ts_4_valid", 48'(ts_4_valid), 48'(e_v4));
    chk("cyc_send_req", 48'(send_req), 48'(e_send));
    chk("cyc_status_ok", 48'(status_ok), 48'(e_ok));
    chk("cyc_timeout_err", 48'(timeout_err), 48'(e_to));
    chk("cyc_ts_1", ts_1, e_ts1);
    chk("cyc_ts_3", ts_3, e_ts3);
    chk("cyc_ts_4", ts_4, e_ts4);
    chk("cyc_done_cnt", 48'(done_cnt), 48'(e_done));
    chk("cyc_to_cnt", 48'(to_cnt), 48'(e_tocnt));
  end

  // ---------------- directed and random stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_sync(input logic [47:0] ts);
    sync_rx = 1; sync_ts = ts;
    @(negedge clk);
    sync_rx = 0;
  endtask

  task automatic wait_send(input string nm);
    int n = 0;
    while (!send_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 48'(send_req), 48'd1);
  endtask

  task automatic pulse_tx();
    req_tx_done = 1;
    @(negedge clk);
    req_tx_done = 0;
  endtask

  task automatic pulse_resp(input logic [47:0] ts);
    resp_rx = 1; resp_ts = ts;
    @(negedge clk);
    resp_rx = 0;
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  initial begin
    int n, cnt, hs, oks, tos;
    logic [47:0] ts3_exp;
    reset = 1; m_or_s = 0; sync_rx = 0; sync_ts = 0; req_ready = 1;
    req_tx_done = 0; resp_rx = 0; resp_ts = 0;
    tick(3);
    chk("reset_send_req", 48'(send_req), 48'd0);
    chk("reset_done_cnt", 48'(done_cnt), 48'd0);
    chk("reset_ts_1", ts_1, 48'd0);
    reset = 0;
    tick(2);

    // nominal exchange
    do_sync(48'h0000_0002_0010);
    chk("nom_ts_1_valid", 48'(ts_1_valid), 48'd1);
    chk("nom_ts_2_record", 48'(ts_2_record), 48'd1);
    chk("nom_ts_1", ts_1, 48'h0000_0002_0010);
    n = 1;
    while (!send_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("nom_send_latency", 48'(n), 48'(1 + G));
    tick(1);
    chk("nom_send_fall", 48'(send_req), 48'd0);
    tick(39);
    req_tx_done = 1; ts3_exp = timer;
    @(negedge clk);
    req_tx_done = 0;
    chk("nom_ts_3_valid", 48'(ts_3_valid), 48'd1);
    chk("nom_ts_3", ts_3, ts3_exp);
    tick(5);
    pulse_resp(48'h0000_0002_1000);
    chk("nom_ts_4_valid", 48'(ts_4_valid), 48'd1);
    chk("nom_ts_4", ts_4, 48'h0000_0002_1000);
    chk("nom_ok_early", 48'(status_ok), 48'd0);
    tick(1);
    chk("nom_status_ok", 48'(status_ok), 48'd1);
    chk("nom_done_cnt", 48'(done_cnt), 48'd1);
    tick(1);
    chk("nom_ok_once", 48'(status_ok), 48'd0);

    // back-pressure
    req_ready = 0;
    do_sync(rnd48());
    wait_send("bp_send_seen");
    cnt = 0;
    repeat (20) begin
      if (send_req) cnt++;
      @(negedge clk);
    end
    chk("bp_hold", 48'(cnt), 48'd20);
    req_ready = 1; hs = 0;
    repeat (3) begin
      if (send_req && req_ready) hs++;
      @(negedge clk);
    end
    chk("bp_handshakes", 48'(hs), 48'd1);
    pulse_tx(); tick(2); pulse_resp(rnd48()); tick(2);
    chk("bp_done_cnt", 48'(done_cnt), 48'd2);

    // timeout
    do_sync(rnd48());
    wait_send("to_send_seen");
    n = 0; oks = 0;
    while (!timeout_err && n < 1200) begin
      @(negedge clk);
      n++;
      if (status_ok) oks++;
    end
    chk("to_latency", 48'(n), 48'(T + 1));
    chk("to_cnt", 48'(to_cnt), 48'd1);
    chk("to_no_ok", 48'(oks), 48'd0);
    tick(2);

    // overlap: restart during WAIT_RESP, stale resp ignored, sync beats resp
    do_sync(rnd48());
    wait_send("ov_send_a");
    tick(3); pulse_tx(); tick(2);
    do_sync(48'h0000_00AB_0001);
    chk("ov_restart_v1", 48'(ts_1_valid), 48'd1);
    chk("ov_restart_ts1", ts_1, 48'h0000_00AB_0001);
    pulse_resp(rnd48());
    chk("ov_stale_resp", 48'(ts_4_valid), 48'd0);
    wait_send("ov_send_b");
    tick(1); pulse_tx(); tick(1);
    sync_rx = 1; sync_ts = 48'h0000_00CD_0002; resp_rx = 1; resp_ts = rnd48();
    @(negedge clk);
    sync_rx = 0; resp_rx = 0;
    chk("ov_sim_v1", 48'(ts_1_valid), 48'd1);
    chk("ov_sim_v4", 48'(ts_4_valid), 48'd0);
    wait_send("ov_send_c");
    tick(1); pulse_tx(); tick(1); pulse_resp(rnd48()); tick(2);
    chk("ov_done_cnt", 48'(done_cnt), 48'd3);

    // master mode blocks strobes; mode change mid-exchange aborts silently
    m_or_s = 1;
    do_sync(rnd48());
    chk("ms_no_v1", 48'(ts_1_valid), 48'd0);
    m_or_s = 0;
    do_sync(rnd48());
    wait_send("ms_send");
    tick(2);
    m_or_s = 1; tick(2); m_or_s = 0;
    pulse_tx();
    chk("ms_no_v3", 48'(ts_3_valid), 48'd0);
    tos = 0;
    repeat (T + 50) begin
      @(negedge clk);
      if (timeout_err) tos++;
    end
    chk("ms_no_timeout", 48'(tos), 48'd0);
    chk("ms_to_cnt", 48'(to_cnt), 48'd1);

    // reset mid WAIT_TX
    do_sync(rnd48());
    wait_send("rst_send");
    tick(5);
    reset = 1;
    #1;
    chk("rst_ts_1", ts_1, 48'd0);
    chk("rst_done_cnt", 48'(done_cnt), 48'd0);
    chk("rst_to_cnt", 48'(to_cnt), 48'd0);
    @(negedge clk);
    reset = 0;
    pulse_tx();
    chk("rst_no_v3", 48'(ts_3_valid), 48'd0);
    tick(2);

    // counter saturation
    force dut.r_done_cnt = 16'hFFFF;
    preload = 1;
    @(negedge clk);
    release dut.r_done_cnt;
    preload = 0;
    do_sync(rnd48());
    wait_send("sat_send");
    tick(1); pulse_tx(); tick(1); pulse_resp(rnd48());
    chk("sat_ok", 48'(status_ok | 1'b0), 48'd0);
    tick(1);
    chk("sat_status_ok", 48'(status_ok), 48'd1);
    chk("sat_done_cnt", 48'(done_cnt), 48'hFFFF);

    // randomized traffic against the model
    repeat (6000) begin
      sync_rx     = ($urandom_range(0, 149) == 0);
      sync_ts     = rnd48();
      req_ready   = ($urandom_range(0, 3) != 0);
      req_tx_done = ($urandom_range(0, 15) == 0);
      resp_rx     = ($urandom_range(0, 15) == 0);
      resp_ts     = rnd48();
      if ($urandom_range(0, 799) == 0) m_or_s = 1;
      else if (m_or_s && $urandom_range(0, 19) == 0) m_or_s = 0;
      reset = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
    end
    sync_rx = 0; req_tx_done = 0; resp_rx = 0; reset = 0; m_or_s = 0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
